if_fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the PC and drives an instruction memory through a request/response handshake.
- Produces the PC, PC+4 and instruction triple that the IF/ID pipeline register captures.
- Honours the stall_IF_ID hold from hazard control, and takes redirects from the branch/JAL resolution logic.
- Squashes wrong-path fetches, including a response still in flight at redirect time.

---
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem handshake,
// and presents the PC / PC+4 / instruction triple to the IF/ID register.
module if_fetch_unit #(
    parameter int                         INST_WIDTH      = 32,
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst_n,
    input  logic                       stall_IF_ID,
    input  logic                       redirect_valid,
    input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [INST_ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [INST_WIDTH-1:0]      imem_rsp_data,
    output logic                       inst_valid_o,
    output logic [INST_ADDR_WIDTH-1:0] PC_IF_ID_i,
    output logic [INST_ADDR_WIDTH-1:0] PC_plus_4_IF_ID_i,
    output logic [INST_WIDTH-1:0]      INST_IF_ID_i
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INST_WIDTH-1:0]      inst_buf_q, inst_buf_d;

    logic                       inst_valid;
    logic                       consume;
    logic [INST_ADDR_WIDTH-1:0] pc_plus_4;
    logic [INST_ADDR_WIDTH-1:0] redirect_aligned;

    assign pc_plus_4        = pc_q + INST_ADDR_WIDTH'(4);
    // Redirect targets are word-aligned by masking rather than slicing so every bit is used.
    assign redirect_aligned = redirect_pc & ~INST_ADDR_WIDTH'(3);
    assign inst_valid       = !redirect_valid &&
                              ((state_q == S_WAIT && imem_rsp_valid) || state_q == S_HOLD);
    assign consume          = inst_valid && !stall_IF_ID;

    assign imem_req_valid    = (state_q == S_FETCH) && !redirect_valid;
    assign imem_req_addr     = pc_q;
    assign inst_valid_o      = inst_valid;
    assign PC_IF_ID_i        = inst_valid ? pc_q : '0;
    assign PC_plus_4_IF_ID_i = inst_valid ? pc_plus_4 : '0;

    always_comb begin
        INST_IF_ID_i = '0;
        if (inst_valid) begin
            INST_IF_ID_i = (state_q == S_HOLD) ? inst_buf_q : imem_rsp_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_buf_d = inst_buf_q;
        if (redirect_valid) begin
            pc_d = redirect_aligned;
            // A request already accepted still owes a response; park in DRAIN to swallow it.
            case (state_q)
                S_WAIT, S_DRAIN: state_d = imem_rsp_valid ? S_FETCH : S_DRAIN;
                default:         state_d = S_FETCH;
            endcase
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_req_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (consume) begin
                            pc_d    = pc_plus_4;
                            state_d = S_FETCH;
                        end else begin
                            inst_buf_d = imem_rsp_data;
                            state_d    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        pc_d    = pc_plus_4;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    if (imem_rsp_valid) state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            inst_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_buf_q <= inst_buf_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; two instances share stimulus and differ only in RESET_PC.
module tb_if_fetch_unit;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        stall_IF_ID;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        req_valid, inst_valid;
    logic [31:0] req_addr, pc_o, pc4_o, inst_o;
    logic        req_valid_b, inst_valid_b;
    logic [31:0] req_addr_b, pc_o_b, pc4_o_b, inst_o_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 cpu_clk = ~cpu_clk;

    if_fetch_unit #(.INST_WIDTH(32), .INST_ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .stall_IF_ID(stall_IF_ID),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid_o(inst_valid), .PC_IF_ID_i(pc_o), .PC_plus_4_IF_ID_i(pc4_o),
        .INST_IF_ID_i(inst_o)
    );

    if_fetch_unit #(.INST_WIDTH(32), .INST_ADDR_WIDTH(32), .RESET_PC(32'h80)) dut_b (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .stall_IF_ID(stall_IF_ID),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(req_valid_b), .imem_req_ready(imem_req_ready), .imem_req_addr(req_addr_b),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid_o(inst_valid_b), .PC_IF_ID_i(pc_o_b), .PC_plus_4_IF_ID_i(pc4_o_b),
        .INST_IF_ID_i(inst_o_b)
    );

    // Advance into the next cycle; inputs are driven here, outputs sampled 1ns later.
    task automatic cyc();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        stall_IF_ID = 0; redirect_valid = 0; redirect_pc = '0;
        imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    endtask

    task automatic test_reset();
        cpu_rst_n = 0; idle_inputs();
        cyc(); cyc();
        cpu_rst_n = 1;
        settle();
        n_chk++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL reset_req_valid: got %b exp 1", req_valid); end
        n_chk++; if (req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h exp 0", req_addr); end
        n_chk++; if (req_addr_b !== 32'h80) begin n_fail++; $display("FAIL reset_req_addr_b: got %h exp 80", req_addr_b); end
        n_chk++; if ({inst_valid, pc_o, pc4_o, inst_o} !== '0) begin n_fail++;
            $display("FAIL reset_triple: got v=%b pc=%h pc4=%h inst=%h exp all 0", inst_valid, pc_o, pc4_o, inst_o); end
    endtask

    task automatic test_fetch();
        imem_req_ready = 1; settle();
        n_chk++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin n_fail++;
            $display("FAIL fetch_req0: got v=%b a=%h exp v=1 a=0", req_valid, req_addr); end
        cyc(); imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0000_0093; settle();
        n_chk++; if ({inst_valid, pc_o, pc4_o, inst_o} !== {1'b1, 32'h0, 32'h4, 32'h0000_0093}) begin n_fail++;
            $display("FAIL fetch_inst0: got v=%b pc=%h pc4=%h inst=%h exp 1/0/4/00000093", inst_valid, pc_o, pc4_o, inst_o); end
        cyc(); imem_rsp_valid = 0; imem_req_ready = 1; settle();
        n_chk++; if (req_valid !== 1'b1 || req_addr !== 32'h4 || inst_valid !== 1'b0) begin n_fail++;
            $display("FAIL fetch_req4: got v=%b a=%h iv=%b exp v=1 a=4 iv=0", req_valid, req_addr, inst_valid); end
        cyc(); imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0010_0113; settle();
        n_chk++; if ({inst_valid, pc_o, pc4_o, inst_o} !== {1'b1, 32'h4, 32'h8, 32'h0010_0113}) begin n_fail++;
            $display("FAIL fetch_inst4: got v=%b pc=%h pc4=%h inst=%h exp 1/4/8/00100113", inst_valid, pc_o, pc4_o, inst_o); end
        cyc(); imem_rsp_valid = 0;
    endtask

    task automatic test_stall_hold();
        imem_req_ready = 1; settle();
        n_chk++; if (req_addr !== 32'h8) begin n_fail++; $display("FAIL stall_req8: got %h exp 8", req_addr); end
        cyc(); imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0020_8193; stall_IF_ID = 1; settle();
        n_chk++; if ({inst_valid, pc_o, inst_o} !== {1'b1, 32'h8, 32'h0020_8193}) begin n_fail++;
            $display("FAIL stall_wait_out: got v=%b pc=%h inst=%h exp 1/8/00208193", inst_valid, pc_o, inst_o); end
        for (int i = 0; i < 2; i++) begin
            // Garbage on the bus in HOLD must not leak through; the buffered word is presented.
            cyc(); imem_rsp_valid = 0; imem_rsp_data = 32'hBAD0_0000 | i; imem_req_ready = 1; settle();
            n_chk++; if ({inst_valid, pc_o, pc4_o, inst_o} !== {1'b1, 32'h8, 32'hC, 32'h0020_8193}) begin n_fail++;
                $display("FAIL stall_hold_out[%0d]: got v=%b pc=%h pc4=%h inst=%h exp 1/8/c/00208193", i, inst_valid, pc_o, pc4_o, inst_o); end
            n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_hold_noreq[%0d]: got %b exp 0", i, req_valid); end
        end
        stall_IF_ID = 0; settle();
        n_chk++; if (inst_valid !== 1'b1 || inst_o !== 32'h0020_8193) begin n_fail++;
            $display("FAIL stall_release_out: got v=%b inst=%h exp 1/00208193", inst_valid, inst_o); end
        cyc(); settle();
        n_chk++; if (req_valid !== 1'b1 || req_addr !== 32'hC) begin n_fail++;
            $display("FAIL stall_reqC: got v=%b a=%h exp 1/c", req_valid, req_addr); end
        // Complete fetch of 0xC with a consume so the PC reaches 0x10.
        cyc(); imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0031_8213;
        cyc(); imem_rsp_valid = 0;
    endtask

    task automatic test_redirect_outstanding();
        imem_req_ready = 1; settle();
        n_chk++; if (req_addr !== 32'h10) begin n_fail++; $display("FAIL redir_req10: got %h exp 10", req_addr); end
        cyc(); imem_req_ready = 0; redirect_valid = 1; redirect_pc = 32'h40; settle();
        n_chk++; if (inst_valid !== 1'b0 || req_valid !== 1'b0) begin n_fail++;
            $display("FAIL redir_cycle: got iv=%b rv=%b exp 0/0", inst_valid, req_valid); end
        cyc(); redirect_valid = 0; redirect_pc = '0; imem_req_ready = 1; settle();
        n_chk++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin n_fail++;
            $display("FAIL redir_drain_wait: got rv=%b iv=%b exp 0/0", req_valid, inst_valid); end
        cyc(); imem_rsp_valid = 1; imem_rsp_data = 32'h1234_5678; settle();
        n_chk++; if ({inst_valid, pc_o, pc4_o, inst_o} !== '0 || req_valid !== 1'b0) begin n_fail++;
            $display("FAIL redir_drop: got iv=%b pc=%h pc4=%h inst=%h rv=%b exp all 0", inst_valid, pc_o, pc4_o, inst_o, req_valid); end
        cyc(); imem_rsp_valid = 0; imem_req_ready = 0; settle();
        n_chk++; if (req_valid !== 1'b1 || req_addr !== 32'h40) begin n_fail++;
            $display("FAIL redir_req40: got v=%b a=%h exp 1/40", req_valid, req_addr); end
    endtask

    task automatic test_redirect_coincident();
        imem_req_ready = 1;
        cyc(); imem_req_ready = 0;
        imem_rsp_valid = 1; imem_rsp_data = 32'h0041_8293; stall_IF_ID = 1;
        redirect_valid = 1; redirect_pc = 32'h102; settle();
        n_chk++; if ({inst_valid, pc_o, pc4_o, inst_o} !== '0) begin n_fail++;
            $display("FAIL coinc_out: got v=%b pc=%h pc4=%h inst=%h exp all 0", inst_valid, pc_o, pc4_o, inst_o); end
        cyc(); idle_inputs(); settle();
        n_chk++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin n_fail++;
            $display("FAIL coinc_req100: got v=%b a=%h exp 1/100", req_valid, req_addr); end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (req_valid !== 1'b1 || req_addr !== 32'h100) begin n_fail++;
                $display("FAIL bp_req[%0d]: got v=%b a=%h exp 1/100", i, req_valid, req_addr); end
            n_chk++; if ({inst_valid, pc_o, pc4_o, inst_o} !== '0) begin n_fail++;
                $display("FAIL bp_triple[%0d]: got v=%b pc=%h pc4=%h inst=%h exp all 0", i, inst_valid, pc_o, pc4_o, inst_o); end
            cyc();
        end
    endtask

    task automatic test_reset_mid_op();
        // Still in FETCH at 0x100: redirect there to 0x20, which must suppress the request.
        redirect_valid = 1; redirect_pc = 32'h20; imem_req_ready = 1; settle();
        n_chk++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_redir_fetch_noreq: got %b exp 0", req_valid); end
        cyc(); redirect_valid = 0; redirect_pc = '0; settle();
        n_chk++; if (req_valid !== 1'b1 || req_addr !== 32'h20) begin n_fail++;
            $display("FAIL rst_req20: got v=%b a=%h exp 1/20", req_valid, req_addr); end
        cyc(); imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0052_8313; stall_IF_ID = 1;
        cyc(); imem_rsp_valid = 0; settle();
        n_chk++; if ({inst_valid_b, pc_o_b, inst_o_b} !== {1'b1, 32'h20, 32'h0052_8313}) begin n_fail++;
            $display("FAIL rst_hold20: got v=%b pc=%h inst=%h exp 1/20/00528313", inst_valid_b, pc_o_b, inst_o_b); end
        cpu_rst_n = 0; stall_IF_ID = 0;
        cyc(); cpu_rst_n = 1; stall_IF_ID = 1; settle();
        n_chk++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'h80 || inst_valid_b !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_req80: got v=%b a=%h iv=%b exp 1/80/0", req_valid_b, req_addr_b, inst_valid_b); end
        imem_rsp_valid = 1; imem_rsp_data = 32'hDEAD_BEEF; settle();
        n_chk++; if ({inst_valid_b, pc_o_b, inst_o_b} !== '0) begin n_fail++;
            $display("FAIL rst_late_rsp: got v=%b pc=%h inst=%h exp all 0", inst_valid_b, pc_o_b, inst_o_b); end
        cyc(); idle_inputs(); settle();
        n_chk++; if (req_valid_b !== 1'b1 || req_addr_b !== 32'h80) begin n_fail++;
            $display("FAIL rst_after_late: got v=%b a=%h exp 1/80", req_valid_b, req_addr_b); end
    endtask

    task automatic test_pc_wrap();
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
        cyc(); redirect_valid = 0; redirect_pc = '0; imem_req_ready = 1; settle();
        n_chk++; if (req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got %h exp fffffffc", req_addr); end
        cyc(); imem_req_ready = 0; imem_rsp_valid = 1; imem_rsp_data = 32'h0000_006F; settle();
        n_chk++; if ({inst_valid, pc_o, pc4_o, inst_o} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0000_006F}) begin n_fail++;
            $display("FAIL wrap_out: got v=%b pc=%h pc4=%h inst=%h exp 1/fffffffc/0/0000006f", inst_valid, pc_o, pc4_o, inst_o); end
        cyc(); imem_rsp_valid = 0; settle();
        n_chk++; if (req_valid !== 1'b1 || req_addr !== 32'h0) begin n_fail++;
            $display("FAIL wrap_next: got v=%b a=%h exp 1/0", req_valid, req_addr); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall_hold();
        test_redirect_outstanding();
        test_redirect_coincident();
        test_back_pressure();
        test_reset_mid_op();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
